// File: rtl/display_scan_mux.sv
// display_scan_mux - time-multiplexed scanner for the Basys3 4-digit
// 7-segment display. Holds a 4-digit packed-BCD value, rotates through the
// digits at SCAN_HZ and drives the active-low anodes and decimal point.
// The nibble of the scanned digit is presented on bcd for an external
// BCD-to-7-segment decoder.
//
// New values are double-buffered: a load lands in a shadow register and is
// copied into the active register only at the frame boundary. As a result,
// a partially updated frame is never displayed. A load on the boundary edge
// itself goes straight to the active register.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to keep the anodes of
// leading-zero digits off. Digit 0, and any digit with its decimal point
// enabled (plus every digit below it), is always shown.
module display_scan_mux #(
   parameter int CLK_HZ    = 100000000,
   parameter int SCAN_HZ   = 1000,
   parameter int BLANK_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   output logic [3:0]  bcd,
   output logic [3:0]  an,
   output logic        dp,
   output logic        frame_tick,
   output logic        bcd_err
);

   localparam int DIV = CLK_HZ / SCAN_HZ;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

   // A slot must hold the blanking window plus at least two lit cycles.
   generate
      if (DIV < BLANK_CYC + 2) begin : g_bad_div
         $error("display_scan_mux: CLK_HZ/SCAN_HZ must be at least BLANK_CYC+2");
      end
   endgenerate

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic          pending;
   logic [15:0]   shadow_val;
   logic [3:0]    shadow_dp;
   logic [15:0]   active_val;
   logic [3:0]    active_dp;

   logic          slot_end;
   logic          boundary;
   logic [3:0]    cur_nibble;
   logic          cur_dp;
   logic [3:0]    show_mask;
   logic          anode_on;
   logic [3:0]    an_next;
   logic          value_bad;

   assign slot_end = (cnt == CNT_LAST);
   assign boundary = slot_end && (idx == 2'd3);

   // Select the nibble and decimal point of the digit being scanned.
   always_comb begin
      cur_nibble = 4'd0;
      cur_dp     = 1'b0;
      case (idx)
         2'd0: begin cur_nibble = active_val[3:0];   cur_dp = active_dp[0]; end
         2'd1: begin cur_nibble = active_val[7:4];   cur_dp = active_dp[1]; end
         2'd2: begin cur_nibble = active_val[11:8];  cur_dp = active_dp[2]; end
         default: begin cur_nibble = active_val[15:12]; cur_dp = active_dp[3]; end
      endcase
   end

   // Flag any nibble of the active value that is not a decimal digit.
   always_comb begin
      value_bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (active_val[i*4 +: 4] > 4'd9) begin
            value_bad = 1'b1;
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic keep;

   // Walk down from digit 3: once a non-zero nibble or a lit decimal point
   // is seen, that digit and every digit below it stay visible.
   always_comb begin
      show_mask = 4'b0001;
      keep      = 1'b0;
      for (int i = 3; i >= 1; i--) begin
         keep = keep | (active_val[i*4 +: 4] != 4'd0) | active_dp[i];
         show_mask[i] = keep;
      end
   end
`else
   assign show_mask = 4'b1111;
`endif

   // Decide the anode pattern for the current cycle of the slot.
   always_comb begin
      anode_on = (cnt >= BLANK_END) && show_mask[idx];
      an_next  = 4'b1111;
      if (anode_on) begin
         an_next = ~(4'b0001 << idx);
      end
   end

   // Prescaler and digit index: advance one digit every DIV cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         idx <= 2'd0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Shadow/active double buffer; the active value only moves at a frame
   // boundary, and a load on the boundary itself beats an older shadow.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending    <= 1'b0;
         shadow_val <= 16'd0;
         shadow_dp  <= 4'd0;
         active_val <= 16'd0;
         active_dp  <= 4'd0;
      end else if (boundary) begin
         if (load) begin
            active_val <= value;
            active_dp  <= dp_in;
         end else if (pending) begin
            active_val <= shadow_val;
            active_dp  <= shadow_dp;
         end
         pending <= 1'b0;
      end else if (load) begin
         shadow_val <= value;
         shadow_dp  <= dp_in;
         pending    <= 1'b1;
      end
   end

   // Registered pin drivers, computed from the state before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         bcd        <= 4'd0;
         an         <= 4'b1111;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
         bcd_err    <= 1'b0;
      end else begin
         bcd        <= cur_nibble;
         an         <= an_next;
         dp         <= anode_on ? ~cur_dp : 1'b1;
         frame_tick <= boundary;
         bcd_err    <= value_bad;
      end
   end

endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux - self-checking bench for display_scan_mux using the
// small configuration CLK_HZ=1000, SCAN_HZ=100 (DIV=10), BLANK_CYC=2.
// A reference model derives the scan position from the elapsed cycle count
// and tracks the displayed value as "the last load of the previous frame".
// Honours LEADING_ZERO_BLANK_EN when the bench is built with it.
module tb_display_scan_mux;

   localparam int CLK_HZ    = 1000;
   localparam int SCAN_HZ   = 100;
   localparam int BLANK_CYC = 2;
   localparam int DIV       = CLK_HZ / SCAN_HZ;

`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value = 16'd0;
   logic [3:0]  dp_in = 4'd0;
   logic [3:0]  bcd;
   logic [3:0]  an;
   logic        dp;
   logic        frame_tick;
   logic        bcd_err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [15:0] m_active = 16'd0;
   logic [3:0]  m_active_dp = 4'd0;
   logic [15:0] m_shadow = 16'd0;
   logic [3:0]  m_shadow_dp = 4'd0;
   bit          m_pending = 1'b0;

   typedef struct {
      int         k;
      logic [3:0] an;
      logic [3:0] bcd;
      logic       ft;
   } vec_t;

   vec_t tbl[12];

   display_scan_mux #(
      .CLK_HZ(CLK_HZ),
      .SCAN_HZ(SCAN_HZ),
      .BLANK_CYC(BLANK_CYC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .load(load),
      .value(value),
      .dp_in(dp_in),
      .bcd(bcd),
      .an(an),
      .dp(dp),
      .frame_tick(frame_tick),
      .bcd_err(bcd_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
      end
   endtask

   // Digit d is lit unless leading-zero blanking hides it.
   function automatic bit shown(input int d);
      if (!LZB || d == 0) return 1'b1;
      return ((m_active >> (4 * d)) != 16'd0) || ((m_active_dp >> d) != 4'd0);
   endfunction

   // One clock edge: predict, clock, compare, then advance the model.
   task automatic applyStimulus(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] d);
      int phase;
      int digit;
      bit on;
      bit bnd;
      bit bad;
      logic [3:0] e_an;
      logic [3:0] e_bcd;
      logic       e_dp;
      logic       e_ft;
      logic       e_err;
      rst = r;
      load = ld;
      value = v;
      dp_in = d;
      phase = cyc % DIV;
      digit = (cyc / DIV) % 4;
      bnd = (phase == DIV - 1) && (digit == 3);
      if (r) begin
         e_an = 4'hF; e_bcd = 4'd0; e_dp = 1'b1; e_ft = 1'b0; e_err = 1'b0;
      end else begin
         on = (phase >= BLANK_CYC) && shown(digit);
         e_an = on ? (4'hF ^ 4'(1 << digit)) : 4'hF;
         e_dp = on ? !m_active_dp[digit] : 1'b1;
         e_bcd = 4'((m_active >> (4 * digit)) & 16'hF);
         e_ft = bnd;
         bad = 1'b0;
         for (int i = 0; i < 4; i++) begin
            if (((m_active >> (4 * i)) & 16'hF) > 16'd9) bad = 1'b1;
         end
         e_err = bad;
      end
      @(posedge clk);
      #1;
      if (r) begin
         cyc = 0;
         m_active = 16'd0; m_active_dp = 4'd0;
         m_shadow = 16'd0; m_shadow_dp = 4'd0;
         m_pending = 1'b0;
      end else begin
         cyc++;
         if (bnd) begin
            if (ld) begin
               m_active = v; m_active_dp = d;
            end else if (m_pending) begin
               m_active = m_shadow; m_active_dp = m_shadow_dp;
            end
            m_pending = 1'b0;
         end else if (ld) begin
            m_shadow = v; m_shadow_dp = d; m_pending = 1'b1;
         end
      end
      checkOutput("model_an", 16'(an), 16'(e_an));
      checkOutput("model_bcd", 16'(bcd), 16'(e_bcd));
      checkOutput("model_dp", 16'(dp), 16'(e_dp));
      checkOutput("model_frame_tick", 16'(frame_tick), 16'(e_ft));
      checkOutput("model_bcd_err", 16'(bcd_err), 16'(e_err));
      rst = 1'b0;
      load = 1'b0;
   endtask

   task automatic runTo(input int k);
      while (cyc < k) applyStimulus(1'b0, 1'b0, 16'd0, 4'd0);
   endtask

   initial begin
      logic [15:0] rv;
      tbl[0]  = '{k: 1,  an: 4'b1111, bcd: 4'd0, ft: 1'b0};
      tbl[1]  = '{k: 2,  an: 4'b1111, bcd: 4'd0, ft: 1'b0};
      tbl[2]  = '{k: 3,  an: 4'b1110, bcd: 4'd0, ft: 1'b0};
      tbl[3]  = '{k: 10, an: 4'b1110, bcd: 4'd0, ft: 1'b0};
      tbl[4]  = '{k: 11, an: 4'b1111, bcd: 4'd0, ft: 1'b0};
      tbl[5]  = '{k: 13, an: LZB ? 4'b1111 : 4'b1101, bcd: 4'd0, ft: 1'b0};
      tbl[6]  = '{k: 23, an: LZB ? 4'b1111 : 4'b1011, bcd: 4'd0, ft: 1'b0};
      tbl[7]  = '{k: 33, an: LZB ? 4'b1111 : 4'b0111, bcd: 4'd0, ft: 1'b0};
      tbl[8]  = '{k: 39, an: LZB ? 4'b1111 : 4'b0111, bcd: 4'd0, ft: 1'b0};
      tbl[9]  = '{k: 40, an: LZB ? 4'b1111 : 4'b0111, bcd: 4'd0, ft: 1'b1};
      tbl[10] = '{k: 41, an: 4'b1111, bcd: 4'd0, ft: 1'b0};
      tbl[11] = '{k: 43, an: 4'b1110, bcd: 4'd0, ft: 1'b0};

      // Reset state, then idle scanning against the table.
      applyStimulus(1'b1, 1'b0, 16'd0, 4'd0);
      checkOutput("reset_an", 16'(an), 16'hF);
      checkOutput("reset_dp", 16'(dp), 16'h1);
      for (int i = 0; i < 12; i++) begin
         runTo(tbl[i].k);
         checkOutput("idle_an", 16'(an), 16'(tbl[i].an));
         checkOutput("idle_bcd", 16'(bcd), 16'(tbl[i].bcd));
         checkOutput("idle_frame_tick", 16'(frame_tick), 16'(tbl[i].ft));
      end

      // Load mid-frame: old frame finishes, new value after the boundary.
      applyStimulus(1'b1, 1'b0, 16'd0, 4'd0);
      runTo(4);
      applyStimulus(1'b0, 1'b1, 16'h1234, 4'b0100);
      runTo(23);
      checkOutput("old_frame_bcd", 16'(bcd), 16'h0);
      runTo(43);
      checkOutput("d0_an", 16'(an), 16'hE);
      checkOutput("d0_bcd", 16'(bcd), 16'h4);
      checkOutput("d0_dp", 16'(dp), 16'h1);
      runTo(53);
      checkOutput("d1_bcd", 16'(bcd), 16'h3);
      runTo(63);
      checkOutput("d2_an", 16'(an), 16'hB);
      checkOutput("d2_bcd", 16'(bcd), 16'h2);
      checkOutput("d2_dp", 16'(dp), 16'h0);
      runTo(73);
      checkOutput("d3_an", 16'(an), 16'h7);
      checkOutput("d3_bcd", 16'(bcd), 16'h1);
      checkOutput("d3_dp", 16'(dp), 16'h1);

      // Two loads in one frame: only the last is shown.
      applyStimulus(1'b1, 1'b0, 16'd0, 4'd0);
      runTo(11);
      applyStimulus(1'b0, 1'b1, 16'h1111, 4'd0);
      runTo(19);
      applyStimulus(1'b0, 1'b1, 16'h5678, 4'd0);
      runTo(43);
      checkOutput("last_load_d0", 16'(bcd), 16'h8);
      runTo(73);
      checkOutput("last_load_d3", 16'(bcd), 16'h5);

      // Load on the boundary edge beats an older pending shadow.
      runTo(69);
      applyStimulus(1'b0, 1'b1, 16'h1111, 4'd0);
      runTo(79);
      applyStimulus(1'b0, 1'b1, 16'h9999, 4'd0);
      applyStimulus(1'b0, 1'b0, 16'd0, 4'd0);
      checkOutput("boundary_load_bcd", 16'(bcd), 16'h9);
      runTo(123);
      checkOutput("no_stale_an", 16'(an), 16'hE);
      checkOutput("no_stale_bcd", 16'(bcd), 16'h9);

      // Invalid BCD nibble raises bcd_err for the frames it is active.
      runTo(129);
      applyStimulus(1'b0, 1'b1, 16'h00A3, 4'd0);
      runTo(160);
      checkOutput("err_before", 16'(bcd_err), 16'h0);
      applyStimulus(1'b0, 1'b0, 16'd0, 4'd0);
      checkOutput("err_set", 16'(bcd_err), 16'h1);
      runTo(173);
      checkOutput("err_d1_an", 16'(an), 16'hD);
      checkOutput("err_d1_bcd", 16'(bcd), 16'hA);
      runTo(174);
      applyStimulus(1'b0, 1'b1, 16'h0042, 4'd0);
      runTo(200);
      checkOutput("err_held", 16'(bcd_err), 16'h1);
      applyStimulus(1'b0, 1'b0, 16'd0, 4'd0);
      checkOutput("err_clear", 16'(bcd_err), 16'h0);

      // Reset mid-slot of digit 2 with a load pending.
      runTo(221);
      applyStimulus(1'b0, 1'b1, 16'h7777, 4'd0);
      runTo(224);
      applyStimulus(1'b1, 1'b0, 16'd0, 4'd0);
      checkOutput("rst_an", 16'(an), 16'hF);
      checkOutput("rst_bcd", 16'(bcd), 16'h0);
      checkOutput("rst_frame_tick", 16'(frame_tick), 16'h0);
      applyStimulus(1'b0, 1'b1, 16'h0042, 4'd0);
      runTo(3);
      checkOutput("restart_an", 16'(an), 16'hE);
      checkOutput("restart_bcd", 16'(bcd), 16'h0);
      runTo(43);
      checkOutput("post_rst_d0", 16'(bcd), 16'h2);
      runTo(53);
      checkOutput("post_rst_d1_an", 16'(an), 16'hD);
      runTo(63);
      checkOutput("post_rst_d2_an", 16'(an), LZB ? 16'hF : 16'hB);
      runTo(73);
      checkOutput("post_rst_d3_an", 16'(an), LZB ? 16'hF : 16'h7);

      // Randomized traffic checked cycle by cycle against the model.
      for (int n = 0; n < 4000; n++) begin
         rv = 16'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            for (int j = 0; j < 4; j++) rv[j*4 +: 4] = 4'(rv[j*4 +: 4] % 10);
         end
         if ($urandom_range(0, 2) == 0) rv[15:8] = 8'h00;
         applyStimulus($urandom_range(0, 499) == 0, $urandom_range(0, 5) == 0, rv, 4'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
